xy_resource_ni: RTL
===================

Name: xy_resource_ni

Overview:
- Network interface for the resource (local) port of an xy_switch.
- TX: accepts host packets into a TX FIFO and writes them into the switch's resource input FIFO, respecting that FIFO's full flag.
- RX: receives packets from the switch's resource output into an RX FIFO and exposes full/overflow back to the switch, so it acts as the switch's "next FIFO".
- Checks that received packets are addressed to this node.

Parameters:
- X_CORD, 0, node X coordinate; compared against received X address.
- Y_CORD, 0, node Y coordinate; compared against received Y address.
- PCKT_XADDR_W, 4, X address width.
- PCKT_YADDR_W, 4, Y address width.
- PCKT_DATA_W, 8, payload width.
- PCKT_W, PCKT_XADDR_W+PCKT_YADDR_W+PCKT_DATA_W, packet width. Format is {xaddr (MSBs), yaddr, data (LSBs)}.
- TX_FIFO_DEPTH_W, 3, TX FIFO depth = 2**TX_FIFO_DEPTH_W.
- RX_FIFO_DEPTH_W, 3, RX FIFO depth = 2**RX_FIFO_DEPTH_W.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- tx_valid_i  in  1  host packet valid.
- tx_x_i  in  PCKT_XADDR_W  destination X.
- tx_y_i  in  PCKT_YADDR_W  destination Y.
- tx_data_i  in  PCKT_DATA_W  payload.
- tx_ready_o  out  1  TX FIFO not full.
- rx_valid_o  out  1  RX FIFO not empty.
- rx_data_o  out  PCKT_DATA_W  payload at the RX FIFO head.
- rx_ready_i  in  1  host consumes the RX head.
- wr_en_o  out  1  write strobe into the switch resource input.
- pckt_o  out  PCKT_W  packet into the switch.
- sw_fifo_full_i  in  1  switch resource input FIFO full.
- sw_fifo_overflow_i  in  1  switch resource input FIFO overflow.
- wr_en_i  in  1  write strobe from the switch resource output.
- pckt_i  in  PCKT_W  packet from the switch.
- rx_fifo_full_o  out  1  RX FIFO full (drives the switch's nxt_fifo_full_i).
- rx_fifo_overflow_o  out  1  one-cycle pulse: write dropped because the RX FIFO was full.
- misroute_err_o  out  1  sticky: a received packet's address did not equal (X_CORD, Y_CORD).
- tx_err_o  out  1  sticky: sw_fifo_overflow_i was seen high.
- tx_cnt_o  out  16  packets sent; saturates at 16'hFFFF.
- rx_cnt_o  out  16  packets accepted into the RX FIFO; saturates at 16'hFFFF.

Behaviour:
- Reset, asynchronous:
  - Both FIFOs empty; all counters and sticky flags are 0.
  - Outputs: wr_en_o=0, pckt_o=0, rx_valid_o=0, rx_fifo_full_o=0, rx_fifo_overflow_o=0, tx_ready_o=1.
  - Reset mid-operation discards all buffered packets immediately.
- TX push:
  - Occurs when tx_valid_i & tx_ready_o; the FIFO stores {tx_x_i, tx_y_i, tx_data_i}.
  - tx_ready_o = (tx_count != depth), based on the registered count only. A full FIFO refuses a push even when a pop happens in the same cycle.
- TX issue (combinational):
  - wr_en_o = tx_count!=0 & !sw_fifo_full_i.
  - pckt_o = TX head when wr_en_o=1, else 0.
  - The head pops on each wr_en_o.
  - Minimum push-to-wr_en_o latency is 1 cycle (no bypass). Back-to-back issue is one packet per cycle.
  - Push and pop in the same cycle leave the count unchanged. Pointers wrap modulo depth; counts are DEPTH_W+1 bits wide.
  - tx_cnt_o increments on each wr_en_o.
- TX error: sw_fifo_overflow_i=1 on any edge sets tx_err_o; it is cleared only by reset.
- RX accept:
  - On wr_en_i, the address fields pckt_i[PCKT_W-1 -: PCKT_XADDR_W] and the following PCKT_YADDR_W bits are compared to X_CORD and Y_CORD.
  - Match and the FIFO was not full at the start of the cycle: store the data field and increment rx_cnt_o.
  - Match and full: drop the packet; rx_fifo_overflow_o=1 for the next cycle only.
  - Mismatch: drop the packet and set misroute_err_o (sticky). There is no overflow pulse, even if the FIFO is full.
- RX outputs:
  - rx_fifo_full_o = (rx_count == depth), registered-count based. A simultaneous pop does not admit a write into a full FIFO.
  - rx_valid_o = rx_count != 0; rx_data_o is the head (0 when empty). The head pops on rx_valid_o & rx_ready_i.
  - Write into an empty FIFO gives rx_valid_o one cycle later.
- Simultaneous events: RX and TX paths are independent. All events in one cycle (TX push, TX pop, RX write, RX pop) are handled in that same cycle.
- Counter saturation: both counters hold at 16'hFFFF; further events do not wrap them.

Test Plan:
Setup for all scenarios: X_CORD=1, Y_CORD=2, widths 4/4/8, both depths 8.
1. Reset: assert rst_ni=0 asynchronously between edges -> outputs clear immediately; tx_ready_o=1, wr_en_o=0, rx_fifo_full_o=0, counters 0.
2. Single TX: push x=3, y=0, data=8'hA5 with sw_fifo_full_i=0 -> next cycle wr_en_o=1, pckt_o=16'h30A5 for exactly one cycle; tx_cnt_o=1.
3. TX backpressure: hold sw_fifo_full_i=1 and push 8 packets (data 0..7) -> tx_ready_o=0 after the 8th push, no wr_en_o; release full -> 8 consecutive wr_en_o with data 0..7 in order, then tx_ready_o=1. Separately, pulse sw_fifo_overflow_i -> tx_err_o=1 and it holds.
4. RX fill: rx_ready_i=0, switch writes pckt_i=16'h12xx with data 0..7 -> rx_fifo_full_o=1 after the 8th write. A 9th write (16'h12FF) -> dropped; rx_fifo_overflow_o pulses one cycle; rx_cnt_o=8. Raise rx_ready_i -> rx_data_o reads 0..7.
5. Misroute: write pckt_i=16'h2233 -> not stored; rx_valid_o stays 0; misroute_err_o=1 and remains set after further valid traffic.
6. Concurrency: with both FIFOs at count 4, in one cycle push TX, issue TX, write RX, and pop RX -> both counts remain 4, and ordering is preserved on both paths.

Source files
------------

// File: rtl/xy_resource_ni.sv
// xy_resource_ni: network interface for the local (resource) port of an xy_switch.
// TX FIFO feeds the switch resource input; RX FIFO receives and checks routed packets.
module xy_resource_ni #(
    parameter int X_CORD          = 0,
    parameter int Y_CORD          = 0,
    parameter int PCKT_XADDR_W    = 4,
    parameter int PCKT_YADDR_W    = 4,
    parameter int PCKT_DATA_W     = 8,
    parameter int PCKT_W          = PCKT_XADDR_W + PCKT_YADDR_W + PCKT_DATA_W,
    parameter int TX_FIFO_DEPTH_W = 3,
    parameter int RX_FIFO_DEPTH_W = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    tx_valid_i,
    input  logic [PCKT_XADDR_W-1:0] tx_x_i,
    input  logic [PCKT_YADDR_W-1:0] tx_y_i,
    input  logic [PCKT_DATA_W-1:0]  tx_data_i,
    output logic                    tx_ready_o,
    output logic                    rx_valid_o,
    output logic [PCKT_DATA_W-1:0]  rx_data_o,
    input  logic                    rx_ready_i,
    output logic                    wr_en_o,
    output logic [PCKT_W-1:0]       pckt_o,
    input  logic                    sw_fifo_full_i,
    input  logic                    sw_fifo_overflow_i,
    input  logic                    wr_en_i,
    input  logic [PCKT_W-1:0]       pckt_i,
    output logic                    rx_fifo_full_o,
    output logic                    rx_fifo_overflow_o,
    output logic                    misroute_err_o,
    output logic                    tx_err_o,
    output logic [15:0]             tx_cnt_o,
    output logic [15:0]             rx_cnt_o
);

    localparam int TD       = TX_FIFO_DEPTH_W;
    localparam int RD       = RX_FIFO_DEPTH_W;
    localparam int TX_DEPTH = 1 << TD;
    localparam int RX_DEPTH = 1 << RD;

    localparam logic [TD:0] TX_FULL = {1'b1, {TD{1'b0}}};
    localparam logic [RD:0] RX_FULL = {1'b1, {RD{1'b0}}};

    localparam logic [PCKT_XADDR_W-1:0] X_C = PCKT_XADDR_W'(X_CORD);
    localparam logic [PCKT_YADDR_W-1:0] Y_C = PCKT_YADDR_W'(Y_CORD);

    localparam logic [TD-1:0] TX_ONE = TD'(1);
    localparam logic [RD-1:0] RX_ONE = RD'(1);
    localparam logic [TD:0]   TXC_ONE = (TD+1)'(1);
    localparam logic [RD:0]   RXC_ONE = (RD+1)'(1);
    localparam logic [15:0]   CNT_MAX = 16'hFFFF;

    // ---------------- TX path ----------------
    logic [PCKT_W-1:0] tx_mem [TX_DEPTH];
    logic [TD-1:0]     tx_wptr;
    logic [TD-1:0]     tx_rptr;
    logic [TD:0]       tx_count;
    logic              tx_push;
    logic              tx_pop;
    logic [PCKT_W-1:0] tx_word;

    assign tx_ready_o = (tx_count != TX_FULL);
    assign tx_push    = tx_valid_i & tx_ready_o;
    assign tx_word    = {tx_x_i, tx_y_i, tx_data_i};
    assign wr_en_o    = (tx_count != '0) & ~sw_fifo_full_i;
    assign tx_pop     = wr_en_o;
    assign pckt_o     = wr_en_o ? tx_mem[tx_rptr] : '0;

    // TX storage; contents need no reset since the count gates every read
    always_ff @(posedge clk_i) begin
        if (tx_push) begin
            tx_mem[tx_wptr] <= tx_word;
        end
    end

    // TX pointers and occupancy; push and pop in one cycle cancel out
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) begin
                tx_wptr <= tx_wptr + TX_ONE;
            end
            if (tx_pop) begin
                tx_rptr <= tx_rptr + TX_ONE;
            end
            if (tx_push && !tx_pop) begin
                tx_count <= tx_count + TXC_ONE;
            end else if (!tx_push && tx_pop) begin
                tx_count <= tx_count - TXC_ONE;
            end
        end
    end

    // Sent-packet counter (saturating) and sticky switch-overflow flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_cnt_o <= '0;
            tx_err_o <= 1'b0;
        end else begin
            if (tx_pop && tx_cnt_o != CNT_MAX) begin
                tx_cnt_o <= tx_cnt_o + 16'd1;
            end
            if (sw_fifo_overflow_i) begin
                tx_err_o <= 1'b1;
            end
        end
    end

    // ---------------- RX path ----------------
    logic [PCKT_DATA_W-1:0]  rx_mem [RX_DEPTH];
    logic [RD-1:0]           rx_wptr;
    logic [RD-1:0]           rx_rptr;
    logic [RD:0]             rx_count;
    logic [PCKT_XADDR_W-1:0] rx_xaddr;
    logic [PCKT_YADDR_W-1:0] rx_yaddr;
    logic [PCKT_DATA_W-1:0]  rx_payload;
    logic                    rx_match;
    logic                    rx_push;
    logic                    rx_pop;

    assign rx_xaddr   = pckt_i[PCKT_W-1 -: PCKT_XADDR_W];
    assign rx_yaddr   = pckt_i[PCKT_W-PCKT_XADDR_W-1 -: PCKT_YADDR_W];
    assign rx_payload = pckt_i[PCKT_DATA_W-1:0];
    assign rx_match   = (rx_xaddr == X_C) && (rx_yaddr == Y_C);

    assign rx_fifo_full_o = (rx_count == RX_FULL);
    assign rx_valid_o     = (rx_count != '0);
    assign rx_data_o      = rx_valid_o ? rx_mem[rx_rptr] : '0;
    assign rx_push        = wr_en_i & rx_match & ~rx_fifo_full_o;
    assign rx_pop         = rx_valid_o & rx_ready_i;

    // RX storage holds only the payload; the address is known to be ours
    always_ff @(posedge clk_i) begin
        if (rx_push) begin
            rx_mem[rx_wptr] <= rx_payload;
        end
    end

    // RX pointers and occupancy; a pop never frees room for a same-cycle write
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) begin
                rx_wptr <= rx_wptr + RX_ONE;
            end
            if (rx_pop) begin
                rx_rptr <= rx_rptr + RX_ONE;
            end
            if (rx_push && !rx_pop) begin
                rx_count <= rx_count + RXC_ONE;
            end else if (!rx_push && rx_pop) begin
                rx_count <= rx_count - RXC_ONE;
            end
        end
    end

    // Overflow pulse, sticky misroute flag and saturating accept counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_fifo_overflow_o <= 1'b0;
            misroute_err_o     <= 1'b0;
            rx_cnt_o           <= '0;
        end else begin
            rx_fifo_overflow_o <= wr_en_i & rx_match & rx_fifo_full_o;
            if (wr_en_i && !rx_match) begin
                misroute_err_o <= 1'b1;
            end
            if (rx_push && rx_cnt_o != CNT_MAX) begin
                rx_cnt_o <= rx_cnt_o + 16'd1;
            end
        end
    end

endmodule
